// File: rtl/icb_pkg.sv
// Shared ICB field widths and the decode helpers used by the ICB address splitter.
package icb_pkg;

  localparam int unsigned ICB_AW     = 32;
  localparam int unsigned ICB_DW     = 32;
  localparam int unsigned ICB_MW     = ICB_DW / 8;
  localparam int unsigned ICB_MAX_AW = 64;

  // Port-id width that can also encode the pseudo-port n.
  function automatic int unsigned splt_ptr_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic logic region_hit(input logic [ICB_MAX_AW-1:0] addr,
                                      input logic [ICB_MAX_AW-1:0] base,
                                      input logic [ICB_MAX_AW-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/icb_splt_addr_dec.sv
// Combinational region decoder: lowest-index hit selects the port, no hit yields SPLT_NUM.
module icb_splt_addr_dec
  import icb_pkg::*;
#(
  parameter int unsigned            AW         = ICB_AW,
  parameter int unsigned            SPLT_NUM   = 4,
  parameter int unsigned            SPLT_PTR_W = splt_ptr_w(SPLT_NUM),
  parameter logic [SPLT_NUM*AW-1:0] BASE_ADDRS = '0,
  parameter logic [SPLT_NUM*AW-1:0] ADDR_MASKS = '0
) (
  input  logic [AW-1:0]         i_addr,
  output logic [SPLT_NUM-1:0]   o_hit,
  output logic [SPLT_PTR_W-1:0] o_tgt_id
);

  always_comb begin
    o_hit = '0;
    for (int unsigned i = 0; i < SPLT_NUM; i++) begin
      o_hit[i] = region_hit(ICB_MAX_AW'(i_addr),
                            ICB_MAX_AW'(BASE_ADDRS[i*AW +: AW]),
                            ICB_MAX_AW'(ADDR_MASKS[i*AW +: AW]));
    end
  end

  // Scan from the top so the lowest-index hit is the last assignment.
  always_comb begin
    o_tgt_id = SPLT_PTR_W'(SPLT_NUM);
    for (int unsigned i = SPLT_NUM; i > 0; i--) begin
      if (o_hit[i-1]) o_tgt_id = SPLT_PTR_W'(i - 1);
    end
  end

endmodule

// File: rtl/icb_addr_splt.sv
// ICB 1-to-N address splitter with in-order responses (one target outstanding at a time).
// Optional macro ICB_ADDR_SPLT_DEFAULT_SLV_EN: misses go to an internal error-responding default slave.
module icb_addr_splt
  import icb_pkg::*;
#(
  parameter int unsigned            AW         = ICB_AW,
  parameter int unsigned            DW         = ICB_DW,
  parameter int unsigned            SPLT_NUM   = 4,
  parameter int unsigned            SPLT_PTR_W = splt_ptr_w(SPLT_NUM),
  parameter int unsigned            OUTS_NUM   = 2,
  parameter logic [SPLT_NUM*AW-1:0] BASE_ADDRS = '0,
  parameter logic [SPLT_NUM*AW-1:0] ADDR_MASKS = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_icb_cmd_valid,
  output logic                         i_icb_cmd_ready,
  input  logic                         i_icb_cmd_read,
  input  logic [AW-1:0]                i_icb_cmd_addr,
  input  logic [DW-1:0]                i_icb_cmd_wdata,
  input  logic [DW/8-1:0]              i_icb_cmd_wmask,
  output logic                         i_icb_rsp_valid,
  input  logic                         i_icb_rsp_ready,
  output logic                         i_icb_rsp_err,
  output logic [DW-1:0]                i_icb_rsp_rdata,
  output logic [SPLT_NUM-1:0]          o_bus_icb_cmd_valid,
  input  logic [SPLT_NUM-1:0]          o_bus_icb_cmd_ready,
  output logic [SPLT_NUM-1:0]          o_bus_icb_cmd_read,
  output logic [SPLT_NUM*AW-1:0]       o_bus_icb_cmd_addr,
  output logic [SPLT_NUM*DW-1:0]       o_bus_icb_cmd_wdata,
  output logic [SPLT_NUM*(DW/8)-1:0]   o_bus_icb_cmd_wmask,
  input  logic [SPLT_NUM-1:0]          o_bus_icb_rsp_valid,
  output logic [SPLT_NUM-1:0]          o_bus_icb_rsp_ready,
  input  logic [SPLT_NUM-1:0]          o_bus_icb_rsp_err,
  input  logic [SPLT_NUM*DW-1:0]       o_bus_icb_rsp_rdata
);

  localparam int unsigned CNT_W = $clog2(OUTS_NUM + 1);
`ifdef ICB_ADDR_SPLT_DEFAULT_SLV_EN
  localparam logic [SPLT_PTR_W-1:0] DFLT_ID = SPLT_PTR_W'(SPLT_NUM);
  localparam logic [SPLT_PTR_W-1:0] MISS_ID = DFLT_ID;
`else
  localparam logic [SPLT_PTR_W-1:0] MISS_ID = SPLT_PTR_W'(SPLT_NUM - 1);
`endif

  logic [SPLT_NUM-1:0]   w_hit;
  logic [SPLT_PTR_W-1:0] w_dec_id;
  logic [SPLT_PTR_W-1:0] w_tgt_id;
  logic                  w_busy;
  logic                  w_stall;
  logic                  w_sel_cmd_ready;
  logic                  w_sel_rsp_valid;
  logic                  w_sel_rsp_err;
  logic [DW-1:0]         w_sel_rsp_rdata;
  logic                  w_cmd_hs;
  logic                  w_rsp_hs;

  logic [CNT_W-1:0]      r_outs_cnt;
  logic [SPLT_PTR_W-1:0] r_cur_id;

  icb_splt_addr_dec #(
    .AW        (AW),
    .SPLT_NUM  (SPLT_NUM),
    .SPLT_PTR_W(SPLT_PTR_W),
    .BASE_ADDRS(BASE_ADDRS),
    .ADDR_MASKS(ADDR_MASKS)
  ) u_dec (
    .i_addr  (i_icb_cmd_addr),
    .o_hit   (w_hit),
    .o_tgt_id(w_dec_id)
  );

  assign w_tgt_id = (|w_hit) ? w_dec_id : MISS_ID;
  assign w_busy   = (r_outs_cnt != '0);
  assign w_stall  = (r_outs_cnt == CNT_W'(OUTS_NUM)) | (w_busy & (w_tgt_id != r_cur_id));

  assign o_bus_icb_cmd_read  = {SPLT_NUM{i_icb_cmd_read}};
  assign o_bus_icb_cmd_addr  = {SPLT_NUM{i_icb_cmd_addr}};
  assign o_bus_icb_cmd_wdata = {SPLT_NUM{i_icb_cmd_wdata}};
  assign o_bus_icb_cmd_wmask = {SPLT_NUM{i_icb_cmd_wmask}};

  always_comb begin
    o_bus_icb_cmd_valid = '0;
    o_bus_icb_rsp_ready = '0;
    w_sel_cmd_ready     = 1'b0;
    w_sel_rsp_valid     = 1'b0;
    w_sel_rsp_err       = 1'b0;
    w_sel_rsp_rdata     = '0;
    for (int unsigned k = 0; k < SPLT_NUM; k++) begin
      if (w_tgt_id == SPLT_PTR_W'(k)) begin
        o_bus_icb_cmd_valid[k] = i_icb_cmd_valid & ~w_stall;
        w_sel_cmd_ready        = o_bus_icb_cmd_ready[k];
      end
      if (r_cur_id == SPLT_PTR_W'(k)) begin
        o_bus_icb_rsp_ready[k] = w_busy & i_icb_rsp_ready;
        w_sel_rsp_valid        = o_bus_icb_rsp_valid[k];
        w_sel_rsp_err          = o_bus_icb_rsp_err[k];
        w_sel_rsp_rdata        = o_bus_icb_rsp_rdata[k*DW +: DW];
      end
    end
`ifdef ICB_ADDR_SPLT_DEFAULT_SLV_EN
    // Default slave accepts immediately; its error response is pending whenever it is current.
    if (w_tgt_id == DFLT_ID) w_sel_cmd_ready = 1'b1;
    if (r_cur_id == DFLT_ID) begin
      w_sel_rsp_valid = 1'b1;
      w_sel_rsp_err   = 1'b1;
      w_sel_rsp_rdata = '0;
    end
`endif
  end

  assign i_icb_cmd_ready = ~w_stall & w_sel_cmd_ready;
  assign i_icb_rsp_valid = w_busy & w_sel_rsp_valid;
  assign i_icb_rsp_err   = w_sel_rsp_err;
  assign i_icb_rsp_rdata = w_sel_rsp_rdata;

  assign w_cmd_hs = i_icb_cmd_valid & i_icb_cmd_ready;
  assign w_rsp_hs = i_icb_rsp_valid & i_icb_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outs_cnt <= '0;
      r_cur_id   <= '0;
    end else begin
      if (w_cmd_hs) r_cur_id <= w_tgt_id;
      if (w_cmd_hs & ~w_rsp_hs)      r_outs_cnt <= r_outs_cnt + CNT_W'(1);
      else if (~w_cmd_hs & w_rsp_hs) r_outs_cnt <= r_outs_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icb_addr_splt.sv
// Random + directed bench for icb_addr_splt with an address-map reference model and response scoreboard.
module tb_icb_addr_splt;

  localparam int unsigned SN = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
  localparam logic [SN*AW-1:0] BASES = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [SN*AW-1:0] MASKS = {SN{32'hFFFF_F000}};
`ifdef ICB_ADDR_SPLT_DEFAULT_SLV_EN
  localparam bit DFLT = 1'b1;
`else
  localparam bit DFLT = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              i_icb_cmd_valid;
  logic              i_icb_cmd_ready;
  logic              i_icb_cmd_read;
  logic [AW-1:0]     i_icb_cmd_addr;
  logic [DW-1:0]     i_icb_cmd_wdata;
  logic [MW-1:0]     i_icb_cmd_wmask;
  logic              i_icb_rsp_valid;
  logic              i_icb_rsp_ready;
  logic              i_icb_rsp_err;
  logic [DW-1:0]     i_icb_rsp_rdata;
  logic [SN-1:0]     o_bus_icb_cmd_valid;
  logic [SN-1:0]     o_bus_icb_cmd_ready;
  logic [SN-1:0]     o_bus_icb_cmd_read;
  logic [SN*AW-1:0]  o_bus_icb_cmd_addr;
  logic [SN*DW-1:0]  o_bus_icb_cmd_wdata;
  logic [SN*MW-1:0]  o_bus_icb_cmd_wmask;
  logic [SN-1:0]     o_bus_icb_rsp_valid;
  logic [SN-1:0]     o_bus_icb_rsp_ready;
  logic [SN-1:0]     o_bus_icb_rsp_err;
  logic [SN*DW-1:0]  o_bus_icb_rsp_rdata;

  icb_addr_splt #(
    .AW        (AW),
    .DW        (DW),
    .SPLT_NUM  (SN),
    .OUTS_NUM  (2),
    .BASE_ADDRS(BASES),
    .ADDR_MASKS(MASKS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_icb_cmd_valid    (i_icb_cmd_valid),
    .i_icb_cmd_ready    (i_icb_cmd_ready),
    .i_icb_cmd_read     (i_icb_cmd_read),
    .i_icb_cmd_addr     (i_icb_cmd_addr),
    .i_icb_cmd_wdata    (i_icb_cmd_wdata),
    .i_icb_cmd_wmask    (i_icb_cmd_wmask),
    .i_icb_rsp_valid    (i_icb_rsp_valid),
    .i_icb_rsp_ready    (i_icb_rsp_ready),
    .i_icb_rsp_err      (i_icb_rsp_err),
    .i_icb_rsp_rdata    (i_icb_rsp_rdata),
    .o_bus_icb_cmd_valid(o_bus_icb_cmd_valid),
    .o_bus_icb_cmd_ready(o_bus_icb_cmd_ready),
    .o_bus_icb_cmd_read (o_bus_icb_cmd_read),
    .o_bus_icb_cmd_addr (o_bus_icb_cmd_addr),
    .o_bus_icb_cmd_wdata(o_bus_icb_cmd_wdata),
    .o_bus_icb_cmd_wmask(o_bus_icb_cmd_wmask),
    .o_bus_icb_rsp_valid(o_bus_icb_rsp_valid),
    .o_bus_icb_rsp_ready(o_bus_icb_rsp_ready),
    .o_bus_icb_rsp_err  (o_bus_icb_rsp_err),
    .o_bus_icb_rsp_rdata(o_bus_icb_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    int   port;
    rsp_t rsp;
  } ent_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  ent_t        sb[$];
  logic [31:0] sq[SN][$];
  logic [32:0] dirq[$];
  logic        m_cmd_hs = 1'b0;
  bit          rnd_en   = 1'b0;
  int          p_vld    = 0;
  int          p_srdy   = 100;
  int          p_srsp   = 100;
  int          p_mrdy   = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit roll(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  // Address map: four consecutive 4 KiB regions from 0; anything above is a miss.
  function automatic int ref_port(input logic [31:0] a);
    if (a < 32'h4000) return int'(a / 32'h1000);
    return DFLT ? int'(SN) : int'(SN) - 1;
  endfunction

  function automatic logic [31:0] slv_data(input int p, input logic [31:0] a);
    logic [3:0] pid;
    pid = 4'(p);
    return a ^ {pid, 28'h5A5_A5A5};
  endfunction

  function automatic rsp_t ref_rsp(input logic [31:0] a);
    rsp_t r;
    int   p;
    p = ref_port(a);
    if (p == int'(SN)) begin
      r.err   = 1'b1;
      r.rdata = '0;
    end else begin
      r.err   = a[3];
      r.rdata = slv_data(p, a);
    end
    return r;
  endfunction

  // Driver: master command source plus behavioural slaves, updated on the falling edge.
  initial begin : driver
    logic [32:0] d;
    logic [31:0] a;
    int          r;
    forever begin
      @(negedge clk);
      if (i_icb_cmd_valid && m_cmd_hs) i_icb_cmd_valid = 1'b0;
      if (rst) begin
        i_icb_cmd_valid = 1'b0;
      end else if (!i_icb_cmd_valid) begin
        if (dirq.size() > 0) begin
          d               = dirq.pop_front();
          i_icb_cmd_read  = d[32];
          i_icb_cmd_addr  = d[31:0];
          i_icb_cmd_valid = 1'b1;
        end else if (rnd_en && roll(p_vld)) begin
          r = int'($urandom_range(9, 0));
          if (r < 8) begin
            a = 32'(r) * 32'h1000;
            if (roll(30)) a = a + (roll(50) ? 32'h0 : 32'hFFC);
            else          a = a + 32'($urandom_range(4095, 0));
          end else begin
            a = $urandom | 32'h0001_0000;
          end
          i_icb_cmd_read  = roll(50);
          i_icb_cmd_addr  = a;
          i_icb_cmd_valid = 1'b1;
        end
        i_icb_cmd_wdata = $urandom;
        i_icb_cmd_wmask = 4'($urandom);
      end
      for (int k = 0; k < int'(SN); k++) begin
        o_bus_icb_cmd_ready[k] = roll(p_srdy);
        if (sq[k].size() > 0 && roll(p_srsp)) begin
          o_bus_icb_rsp_valid[k]         = 1'b1;
          o_bus_icb_rsp_err[k]           = sq[k][0][3];
          o_bus_icb_rsp_rdata[k*DW +: DW] = slv_data(k, sq[k][0]);
        end else begin
          o_bus_icb_rsp_valid[k]         = 1'b0;
          o_bus_icb_rsp_err[k]           = 1'($urandom);
          o_bus_icb_rsp_rdata[k*DW +: DW] = $urandom;
        end
      end
      i_icb_rsp_ready = roll(p_mrdy);
    end
  end

  // Monitor: checks both sides against the reference model shortly before each rising edge.
  initial begin : monitor
    int            p;
    bit            stall;
    logic          exp_rv;
    logic [SN-1:0] exp_vec;
    logic [SN-1:0] exp_rrdy;
    logic          exp_crdy;
    ent_t          e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("rst_rsp_valid", 64'(i_icb_rsp_valid), 64'(0));
        chk("rst_bus_rsp_ready", 64'(o_bus_icb_rsp_ready), 64'(0));
        if (!i_icb_cmd_valid) chk("rst_bus_cmd_valid", 64'(o_bus_icb_cmd_valid), 64'(0));
        sb.delete();
        for (int k = 0; k < int'(SN); k++) sq[k].delete();
        m_cmd_hs = 1'b0;
      end else begin
        exp_rv   = 1'b0;
        exp_rrdy = '0;
        if (sb.size() > 0) begin
          if (sb[0].port == int'(SN)) exp_rv = 1'b1;
          else begin
            exp_rv   = o_bus_icb_rsp_valid[sb[0].port];
            exp_rrdy = SN'(i_icb_rsp_ready) << sb[0].port;
          end
        end
        chk("rsp_valid", 64'(i_icb_rsp_valid), 64'(exp_rv));
        chk("bus_rsp_ready", 64'(o_bus_icb_rsp_ready), 64'(exp_rrdy));
        if (i_icb_rsp_valid && i_icb_rsp_ready) begin
          if (sb.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
          else begin
            e = sb.pop_front();
            chk("rsp_err", 64'(i_icb_rsp_err), 64'(e.rsp.err));
            chk("rsp_rdata", 64'(i_icb_rsp_rdata), 64'(e.rsp.rdata));
          end
        end
        p = 0;
        if (i_icb_cmd_valid) begin
          p        = ref_port(i_icb_cmd_addr);
          stall    = (sb.size() + ((i_icb_rsp_valid && i_icb_rsp_ready) ? 1 : 0) == 2) ||
                     (sb.size() + ((i_icb_rsp_valid && i_icb_rsp_ready) ? 1 : 0) > 0 && e.port != p);
          exp_crdy = !stall && (p == int'(SN) || o_bus_icb_cmd_ready[p]);
          exp_vec  = (!stall && p < int'(SN)) ? (SN'(1) << p) : '0;
          chk("cmd_ready", 64'(i_icb_cmd_ready), 64'(exp_crdy));
          chk("bus_cmd_valid", 64'(o_bus_icb_cmd_valid), 64'(exp_vec));
          if (exp_vec != '0) begin
            chk("bus_cmd_addr", 64'(o_bus_icb_cmd_addr[p*AW +: AW]), 64'(i_icb_cmd_addr));
            chk("bus_cmd_wdata", 64'(o_bus_icb_cmd_wdata[p*DW +: DW]), 64'(i_icb_cmd_wdata));
            chk("bus_cmd_wmask", 64'(o_bus_icb_cmd_wmask[p*MW +: MW]), 64'(i_icb_cmd_wmask));
            chk("bus_cmd_read", 64'(o_bus_icb_cmd_read[p]), 64'(i_icb_cmd_read));
          end
        end else begin
          chk("bus_cmd_valid_idle", 64'(o_bus_icb_cmd_valid), 64'(0));
        end
        m_cmd_hs = i_icb_cmd_valid & i_icb_cmd_ready;
        if (m_cmd_hs) begin
          e.port = p;
          e.rsp  = ref_rsp(i_icb_cmd_addr);
          sb.push_back(e);
        end
        for (int k = 0; k < int'(SN); k++) begin
          if (o_bus_icb_rsp_valid[k] && o_bus_icb_rsp_ready[k] && sq[k].size() > 0) void'(sq[k].pop_front());
          if (o_bus_icb_cmd_valid[k] && o_bus_icb_cmd_ready[k]) sq[k].push_back(o_bus_icb_cmd_addr[k*AW +: AW]);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((dirq.size() > 0 || i_icb_cmd_valid || sb.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sb.size() + dirq.size()), 64'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    rst                 = 1'b1;
    i_icb_cmd_valid     = 1'b0;
    i_icb_cmd_read      = 1'b0;
    i_icb_cmd_addr      = '0;
    i_icb_cmd_wdata     = '0;
    i_icb_cmd_wmask     = '0;
    i_icb_rsp_ready     = 1'b0;
    o_bus_icb_cmd_ready = '0;
    o_bus_icb_rsp_valid = '0;
    o_bus_icb_rsp_err   = '0;
    o_bus_icb_rsp_rdata = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    dirq.push_back({1'b1, 32'h0000_1004});
    wait_idle("drain_read_port1");

    // Two reads to one slave fill the window; the third must wait for a response.
    p_srsp = 0;
    dirq.push_back({1'b1, 32'h0000_2000});
    dirq.push_back({1'b1, 32'h0000_2000});
    dirq.push_back({1'b1, 32'h0000_2008});
    repeat (8) @(negedge clk);
    p_srsp = 100;
    wait_idle("drain_outs_full");

    // A different target is blocked while another slave still owes a response.
    p_srsp = 0;
    dirq.push_back({1'b1, 32'h0000_2000});
    dirq.push_back({1'b0, 32'h0000_0010});
    repeat (6) @(negedge clk);
    p_srsp = 100;
    wait_idle("drain_target_switch");

    // Back-to-back on port 3 with immediate responses overlaps command and response handshakes.
    dirq.push_back({1'b1, 32'h0000_3000});
    dirq.push_back({1'b1, 32'h0000_3004});
    dirq.push_back({1'b0, 32'h0000_3FFC});
    dirq.push_back({1'b1, 32'h0000_3010});
    dirq.push_back({1'b1, 32'h0000_3FF8});
    wait_idle("drain_port3_overlap");

    dirq.push_back({1'b1, 32'h0000_8000});
    dirq.push_back({1'b0, 32'h0000_8000});
    dirq.push_back({1'b1, 32'h0000_4000});
    wait_idle("drain_miss");

    rnd_en = 1'b1;
    p_vld  = 60;
    p_srdy = 70;
    p_srsp = 50;
    p_mrdy = 70;
    repeat (3000) @(negedge clk);
    rnd_en = 1'b0;
    p_srdy = 100;
    p_srsp = 100;
    p_mrdy = 100;
    wait_idle("drain_random");

    // Reset while two responses are outstanding and the slave is presenting one.
    p_srsp = 0;
    dirq.push_back({1'b1, 32'h0000_2000});
    dirq.push_back({1'b1, 32'h0000_2004});
    repeat (6) @(negedge clk);
    chk("outs_before_reset", 64'(sb.size()), 64'(2));
    p_srsp = 100;
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dirq.push_back({1'b1, 32'h0000_0010});
    dirq.push_back({1'b1, 32'h0000_1FFC});
    wait_idle("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
